// File: rtl/bullet_wave_scheduler_pkg.sv
// bullet_pkg: shared state encoding, wave enable masks and counter widths for the bullet wave scheduler.
package bullet_pkg;
    typedef enum logic [2:0] {IDLE, ARM, RUN, HIT_PAUSE, GAP, DONE} state_t;
    localparam int HIT_W = 4;
    localparam int CNT_W = 8;
    localparam logic [3:0] WAVE_MASK [0:7] = '{4'b0001, 4'b0010, 4'b0011, 4'b1111,
                                              4'b1111, 4'b1111, 4'b1111, 4'b1111};
endpackage

// File: rtl/bullet_wave_scheduler_tick_divider.sv
// tick_divider: one-cycle tick every TICK_DIV clocks; clr restarts the count so a tick lands TICK_DIV cycles later.
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic clr,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] tick_cnt;
    assign tick = tick_cnt == W'(TICK_DIV - 1);
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) tick_cnt <= '0;
        else tick_cnt <= (clr || tick) ? '0 : tick_cnt + 1'b1;
    end
endmodule

// File: rtl/bullet_wave_scheduler.sv
// bullet_wave_scheduler: steps generator enables through timed waves and pauses them after player hits.
// Define HIT_LIMIT_EN to end the phase with failed=1 once hit_count reaches MAX_HITS.
module bullet_wave_scheduler
    import bullet_pkg::*;
#(
    parameter int NUM_GEN         = 4,
    parameter int NUM_WAVES       = 4,
    parameter int TICK_DIV        = 50_000_000,
    parameter int WAVE_TICKS      = 8,
    parameter int GAP_TICKS       = 1,
    parameter int HIT_PAUSE_TICKS = 2,
    parameter int MAX_HITS        = 3
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic               player_collision,
    output logic [NUM_GEN-1:0] gen_enable,
    output logic [2:0]         wave_idx,
    output logic               busy,
    output logic               hit_pause,
    output logic [HIT_W-1:0]   hit_count,
    output logic               done,
    output logic               failed
);
    state_t state, nxt;
    logic [CNT_W-1:0] wave_left, left;
    logic [HIT_W-1:0] hit_inc;
    logic coll_d, tick, hit, limit, last, restart;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .clr(nxt != state),
        .tick(tick)
    );

    assign hit     = player_collision & ~coll_d;
    assign hit_inc = hit_count == '1 ? hit_count : hit_count + 1'b1;
    assign last    = wave_idx == 3'(NUM_WAVES - 1);
    assign restart = nxt == ARM && (state == IDLE || state == DONE);

    always_comb begin
        nxt = state;
        if (abort) nxt = IDLE;
        else begin
            case (state)
                IDLE, DONE: nxt = start ? ARM : state;
                ARM:        nxt = RUN;
                RUN:        nxt = hit ? (limit ? DONE : HIT_PAUSE)
                                      : (tick && wave_left == CNT_W'(1)) ? (last ? DONE : GAP) : RUN;
                HIT_PAUSE:  nxt = (tick && left == CNT_W'(1)) ? RUN : HIT_PAUSE;
                GAP:        nxt = (GAP_TICKS == 0 || (tick && left == CNT_W'(1))) ? ARM : GAP;
                default:    nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from nxt so they move on the same edge as the state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            coll_d     <= 1'b0;
            wave_left  <= '0;
            left       <= '0;
            wave_idx   <= '0;
            hit_count  <= '0;
            gen_enable <= '0;
            busy       <= 1'b0;
            hit_pause  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state  <= nxt;
            coll_d <= player_collision;
            if (restart) wave_idx <= '0;
            else if (state == GAP && nxt == ARM) wave_idx <= wave_idx + 1'b1;
            if (restart) hit_count <= '0;
            else if (state == RUN && hit && !abort) hit_count <= hit_inc;
            if (state == ARM) wave_left <= CNT_W'(WAVE_TICKS);
            else if (state == RUN && nxt == RUN && tick) wave_left <= wave_left - 1'b1;
            left <= (state == RUN && nxt == HIT_PAUSE) ? CNT_W'(HIT_PAUSE_TICKS)
                  : (state == RUN && nxt == GAP) ? CNT_W'(GAP_TICKS)
                  : ((state == HIT_PAUSE || state == GAP) && tick) ? left - 1'b1 : left;
            gen_enable <= nxt == RUN ? NUM_GEN'(WAVE_MASK[wave_idx]) : '0;
            busy       <= nxt inside {ARM, RUN, HIT_PAUSE, GAP};
            hit_pause  <= nxt == HIT_PAUSE;
            done       <= nxt == DONE;
        end
    end

`ifdef HIT_LIMIT_EN
    assign limit = hit_inc == HIT_W'(MAX_HITS);
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) failed <= 1'b0;
        else if (restart) failed <= 1'b0;
        else if (state == RUN && nxt == DONE && hit) failed <= 1'b1;
    end
`else
    assign limit  = 1'b0 & (hit_inc == HIT_W'(MAX_HITS));
    assign failed = 1'b0;
`endif
endmodule

// File: tb/tb_bullet_wave_scheduler.sv
// tb_bullet_wave_scheduler: timeline vectors for waves, hits and abort, plus hit-limit and async-reset sequences.
module tb_bullet_wave_scheduler;
    logic       CLOCK_50, resetn, start, abort, player_collision;
    logic [3:0] gen_enable;
    logic [2:0] wave_idx;
    logic       busy, hit_pause, done, failed;
    logic [3:0] hit_count;
    int         checks = 0;
    int         errors = 0;

`ifdef HIT_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    typedef struct {
        logic        start, abort, coll;
        int          cyc;
        logic [14:0] exp;
    } vec_t;
    vec_t v[$];

    bullet_wave_scheduler #(
        .NUM_GEN(4), .NUM_WAVES(4), .TICK_DIV(10), .WAVE_TICKS(3),
        .GAP_TICKS(1), .HIT_PAUSE_TICKS(2), .MAX_HITS(3)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .start(start),
        .abort(abort),
        .player_collision(player_collision),
        .gen_enable(gen_enable),
        .wave_idx(wave_idx),
        .busy(busy),
        .hit_pause(hit_pause),
        .hit_count(hit_count),
        .done(done),
        .failed(failed)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // exp packs {gen_enable, wave_idx, busy, hit_pause, hit_count, done, failed}
    function automatic vec_t mk(input int s, a, c, n, g, i, b, hp, hc, d);
        vec_t r;
        r.start = 1'(s);
        r.abort = 1'(a);
        r.coll  = 1'(c);
        r.cyc   = n;
        r.exp   = {4'(g), 3'(i), 1'(b), 1'(hp), 4'(hc), 1'(d), 1'b0};
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic chk(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {gen_enable, wave_idx, busy, hit_pause, hit_count, done, failed};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gen=%b idx=%0d busy=%b hp=%b hc=%0d done=%b failed=%b, expected gen=%b idx=%0d busy=%b hp=%b hc=%0d done=%b failed=%b",
                     name, act[14:11], act[10:8], act[7], act[6], act[5:2], act[1], act[0],
                     exp[14:11], exp[10:8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic stop;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; player_collision = 1'b0;
        //           s  a  c   n   gen idx busy hp hc done
        v.push_back(mk(1, 0, 0,  1,  0, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  1, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 29,  1, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  0, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  9,  0, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  0, 1, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  2, 1, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 29,  2, 1, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  0, 1, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 10,  0, 2, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  3, 2, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 30,  0, 2, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 10,  0, 3, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1, 15, 3, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 29, 15, 3, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  0, 3, 0, 0, 0, 1));
        v.push_back(mk(0, 0, 0,  5,  0, 3, 0, 0, 0, 1));
        v.push_back(mk(1, 0, 0,  1,  0, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  1, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 14,  1, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 1,  1,  0, 0, 1, 1, 1, 0));
        v.push_back(mk(0, 0, 1, 19,  0, 0, 1, 1, 1, 0));
        v.push_back(mk(0, 0, 1,  1,  1, 0, 1, 0, 1, 0));
        v.push_back(mk(1, 0, 1, 19,  1, 0, 1, 0, 1, 0));
        v.push_back(mk(0, 0, 0,  1,  0, 0, 1, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 10,  0, 1, 1, 0, 1, 0));
        v.push_back(mk(0, 0, 0,  1,  2, 1, 1, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 29,  2, 1, 1, 0, 1, 0));
        v.push_back(mk(0, 0, 1,  1,  0, 1, 1, 1, 2, 0));
        v.push_back(mk(0, 0, 0, 19,  0, 1, 1, 1, 2, 0));
        v.push_back(mk(0, 0, 0,  1,  2, 1, 1, 0, 2, 0));
        v.push_back(mk(0, 0, 0,  9,  2, 1, 1, 0, 2, 0));
        v.push_back(mk(0, 0, 0,  1,  0, 1, 1, 0, 2, 0));
        v.push_back(mk(0, 1, 0,  1,  0, 1, 0, 0, 2, 0));
        v.push_back(mk(0, 0, 0,  3,  0, 1, 0, 0, 2, 0));
        v.push_back(mk(1, 0, 0,  1,  0, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0,  1,  1, 0, 1, 0, 0, 0));

        repeat (2) @(negedge CLOCK_50);
        chk("reset", 15'd0);
        resetn = 1'b1;
        step(3);
        chk("idle_after_reset", 15'd0);

        foreach (v[i]) begin
            start = v[i].start;
            abort = v[i].abort;
            player_collision = v[i].coll;
            step(v[i].cyc);
            chk($sformatf("row%0d", i), v[i].exp);
        end
        start = 1'b0; abort = 1'b0; player_collision = 1'b0;

        for (int k = 1; k <= 3; k++) begin
            player_collision = 1'b1;
            step(1);
            stop = LIM && k == 3;
            chk($sformatf("hit%0d", k), stop ? {4'b0, 3'd0, 1'b0, 1'b0, 4'(k), 1'b1, 1'b1}
                                             : {4'b0, 3'd0, 1'b1, 1'b1, 4'(k), 1'b0, 1'b0});
            player_collision = 1'b0;
            if (!stop) begin
                step(20);
                chk($sformatf("resume%0d", k), {4'b0001, 3'd0, 1'b1, 1'b0, 4'(k), 1'b0, 1'b0});
            end
        end

        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        chk("run_before_reset", {4'b0001, 3'd0, 1'b1, 1'b0, LIM ? 4'd0 : 4'd3, 1'b0, 1'b0});

        #2 resetn = 1'b0;
        #1 chk("async_reset", 15'd0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        step(5);
        chk("post_reset_idle", 15'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
